fpu_req_scheduler: RTL and testbench
====================================

Name: fpu_req_scheduler

Overview:
- Shares one memory-mapped single-precision FPU (ADD/SUB/MUL register interface: A at 0x00, B at 0x04, command at 0x08, result on read data) among N_REQ requesters.
- Round-robin arbiter plus a sequencing FSM. For each granted request it writes A, writes B, issues the command, waits, captures the result and returns it to the winner over a valid/ready response channel.
- Sits between the client ports and the FPU's chip_select/addr/data_in/data_out bus.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- RESULT_WAIT, 1, cycles from the command write to result capture (>=1).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept (one-hot or zero)
- req_op  in  2*N_REQ  op per requester: 1=ADD, 2=SUB, 3=MUL, 0=invalid
- req_a  in  32*N_REQ  operand A per requester
- req_b  in  32*N_REQ  operand B per requester
- rsp_valid  out  N_REQ  response valid, one-hot to the granted requester
- rsp_ready  in  N_REQ  per-requester response accept
- rsp_data  out  32  result word (shared; qualified by rsp_valid)
- fpu_cs  out  1  FPU chip_select
- fpu_addr  out  13  FPU byte address
- fpu_wdata  out  32  FPU data_in
- fpu_rdata  in  32  FPU data_out
- busy  out  1  high whenever state != IDLE
- ops_done  out  CNT_W  completed-response counter

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - All outputs 0.
  - State IDLE; round-robin pointer 0.
  - Latched op/a/b/grant index cleared.
  - Reset mid-transaction aborts immediately. No response is issued and fpu_cs is 0 the next cycle.
- FSM states: IDLE, WR_A, WR_B, WR_CMD, WAIT, RESP.
- IDLE:
  - If any req_valid, select the first valid index at or after the pointer, wrapping modulo N_REQ.
  - Assert req_ready[winner] combinationally in that same cycle.
  - Latch op/a/b/index at the clock edge, then go to WR_A.
  - No valid request: stay in IDLE, req_ready all 0.
- WR_A: fpu_cs=1, fpu_addr=0x000, fpu_wdata=latched A, then WR_B.
- WR_B: fpu_cs=1, fpu_addr=0x004, fpu_wdata=latched B, then WR_CMD.
- WR_CMD: fpu_cs=1, fpu_addr=0x008, fpu_wdata={30'b0, op}, then WAIT with the wait counter loaded to RESULT_WAIT-1.
- WAIT:
  - fpu_cs=0; decrement the counter.
  - When counter==0, capture fpu_rdata into rsp_data at the edge and go to RESP.
- RESP:
  - rsp_valid[index]=1, rsp_data held stable.
  - On rsp_ready[index]: go to IDLE, ops_done increments (wraps at 2^CNT_W), pointer becomes (index+1) mod N_REQ.
  - rsp_ready on other indices is ignored.
- fpu_cs, fpu_addr and fpu_wdata are 0 in every state except WR_A, WR_B and WR_CMD.
- req_ready is 0 in every state except IDLE, so at most one request is in flight.
- Latency: acceptance at cycle T leaves rsp_valid high from T+4+RESULT_WAIT (T+5 by default). Back-to-back throughput is one op per 6 cycles when rsp_ready is held high.
- Op 0 is passed through as command 0; the FPU returns 0x7FC00000, which is delivered normally.
- A requester that drops req_valid without a handshake is simply not granted. Operands are sampled only at the acceptance edge, so later operand changes do not affect an accepted request.
- Response back-pressure: the FSM stays in RESP indefinitely and no new grant is issued.
- Fairness: the winner is rotated to lowest priority after its response completes, so with all requesters valid, grants go 0,1,2,3,0,...

Test Plan:
1. Single requester 0: op=1, A=0x3F800000, B=0x40000000, rsp_ready=1.
   - Bus shows writes 0x000/0x3F800000, 0x004/0x40000000, 0x008/0x00000001.
   - rsp_valid[0] at T+5 with rsp_data=0x40400000; ops_done=1.
2. MUL and SUB:
   - op=3, 0x40000000 * 0x40400000 -> 0x40C00000.
   - op=2, 0x3F800000 - 0x40000000 -> 0xBF800000.
3. All four requesters valid continuously with distinct ops -> grants 0,1,2,3,0; each rsp_data matches its own operands; at most one req_ready per cycle.
4. Hold rsp_ready[1]=0 for 10 cycles while others are pending -> FSM stays in RESP, rsp_data stable, fpu_cs=0, no req_ready. Releasing it lets the next grant go to index 2.
5. op=0 -> rsp_data=0x7FC00000, normal handshake.
6. Assert reset during WR_B -> the next cycle has busy=0, fpu_cs=0, rsp_valid=0 and pointer=0. A fresh request then completes correctly.

Source files
------------

// File: rtl/fpu_req_scheduler.sv
// rtl/fpu_req_scheduler.sv - round-robin scheduler sharing one memory-mapped FPU among requesters
module fpu_req_scheduler #(
  parameter int N_REQ       = 4,
  parameter int RESULT_WAIT = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [2*N_REQ-1:0]    req_op,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  fpu_cs,
  output logic [12:0]           fpu_addr,
  output logic [31:0]           fpu_wdata,
  input  logic [31:0]           fpu_rdata,
  output logic                  busy,
  output logic [CNT_W-1:0]      ops_done
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WAIT_W = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;
  localparam logic [IDX_W:0]    N_SZ     = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [WAIT_W-1:0] WAIT_LD  = WAIT_W'(RESULT_WAIT - 1);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_CMD, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        op_q, op_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  ops_done_q, ops_done_d;

  logic              grant_any;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W:0]    cand;
  logic [1:0]        sel_op;
  logic [31:0]       sel_a, sel_b;

  // Round-robin pick: first valid requester at or after the pointer, wrapping
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= N_SZ) cand = cand - N_SZ;
      if (!grant_any && req_valid[cand[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

  // Operand mux for the current winner
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
      end
    end
  end

  // Per-requester handshake outputs: accept only from IDLE, respond only from RESP
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (state_q == IDLE) && grant_any && (grant_idx == IDX_W'(i));
      rsp_valid[i] = (state_q == RESP) && (idx_q == IDX_W'(i));
    end
  end

  // Sequencer: next state, latched request fields and the FPU bus drive
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    wait_d     = wait_q;
    ops_done_d = ops_done_q;
    fpu_cs     = 1'b0;
    fpu_addr   = '0;
    fpu_wdata  = '0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          idx_d   = grant_idx;
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          state_d = WR_A;
        end
      end
      WR_A: begin
        fpu_cs    = 1'b1;
        fpu_addr  = 13'h000;
        fpu_wdata = a_q;
        state_d   = WR_B;
      end
      WR_B: begin
        fpu_cs    = 1'b1;
        fpu_addr  = 13'h004;
        fpu_wdata = b_q;
        state_d   = WR_CMD;
      end
      WR_CMD: begin
        fpu_cs    = 1'b1;
        fpu_addr  = 13'h008;
        fpu_wdata = {30'b0, op_q};
        wait_d    = WAIT_LD;
        state_d   = WAIT;
      end
      WAIT: begin
        if (wait_q == '0) begin
          rsp_data_d = fpu_rdata;
          state_d    = RESP;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready[idx_q]) begin
          ops_done_d = ops_done_q + CNT_W'(1);
          ptr_d      = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      wait_q     <= '0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      wait_q     <= wait_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign busy     = (state_q != IDLE);
  assign ops_done = ops_done_q;

endmodule

// File: tb/tb_fpu_req_scheduler.sv
// tb/tb_fpu_req_scheduler.sv - self-checking bench for fpu_req_scheduler
module tb_fpu_req_scheduler;
  localparam int N  = 4;
  localparam int RW = 1;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*N-1:0]  req_op;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     rsp_data, fpu_wdata, fpu_rdata;
  logic            fpu_cs, busy;
  logic [12:0]     fpu_addr;
  logic [CW-1:0]   ops_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fpu_req_scheduler #(.N_REQ(N), .RESULT_WAIT(RW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .fpu_cs(fpu_cs), .fpu_addr(fpu_addr), .fpu_wdata(fpu_wdata), .fpu_rdata(fpu_rdata),
    .busy(busy), .ops_done(ops_done)
  );

  // Integer-valued single-precision helpers (|v| < 2^24)
  function automatic logic [31:0] int_to_f32(int v);
    logic [31:0] mag, man;
    int e;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? 32'(-v) : 32'(v);
    e = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) e = i;
    man = (mag << (23 - e)) & 32'h007F_FFFF;
    return {(v < 0), 8'(127 + e), man[22:0]};
  endfunction

  function automatic int f32_to_int(logic [31:0] f);
    int e, mag;
    logic [23:0] m;
    if (f[30:0] == 31'h0) return 0;
    e   = int'(f[30:23]) - 127;
    m   = {1'b1, f[22:0]} >> (23 - e);
    mag = int'(m);
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] fpu_eval(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      2'd1:    return int_to_f32(f32_to_int(a) + f32_to_int(b));
      2'd2:    return int_to_f32(f32_to_int(a) - f32_to_int(b));
      2'd3:    return int_to_f32(f32_to_int(a) * f32_to_int(b));
      default: return 32'h7FC0_0000;
    endcase
  endfunction

  // FPU device model: registers written over the bus, result computed on command write
  logic [31:0] fa, fb, fres;
  always @(posedge clk) begin
    if (reset) begin
      fa <= '0; fb <= '0; fres <= '0;
    end else if (fpu_cs) begin
      case (fpu_addr)
        13'h000: fa   <= fpu_wdata;
        13'h004: fb   <= fpu_wdata;
        13'h008: fres <= fpu_eval(fpu_wdata[1:0], fa, fb);
        default: ;
      endcase
    end
  end
  assign fpu_rdata = fres;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Transaction-level reference: one op in flight, round-robin pointer, fixed timeline
  int          cyc = 0, m_ptr = 0, m_idx = 0, m_acc = 0, m_done = 0;
  bit          m_busy = 0;
  logic [1:0]  m_op;
  logic [31:0] m_a, m_b, m_exp;

  always @(negedge clk) begin
    int win, c, age;
    logic [N-1:0] exp_ready;
    logic exp_cs;
    logic [12:0] exp_addr;
    logic [31:0] exp_wd;
    cyc++;
    if (reset) begin
      m_busy = 0; m_ptr = 0; m_done = 0;
    end else begin
      age = cyc - m_acc;
      check("busy", busy, m_busy);
      check("ops_done", ops_done, 32'(m_done % (1 << CW)));
      win = -1;
      exp_ready = '0;
      if (!m_busy)
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (win < 0 && req_valid[c]) win = c;
        end
      if (win >= 0) exp_ready[win] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      exp_cs   = m_busy && age >= 1 && age <= 3;
      exp_addr = exp_cs ? 13'(4 * (age - 1)) : 13'h0;
      exp_wd   = !exp_cs ? 32'h0 : (age == 1) ? m_a : (age == 2) ? m_b : {30'b0, m_op};
      check("fpu_cs", fpu_cs, exp_cs);
      check("fpu_addr", fpu_addr, exp_addr);
      check("fpu_wdata", fpu_wdata, exp_wd);
      if (m_busy && age >= 4 + RW) begin
        check("rsp_valid", rsp_valid, 32'(1 << m_idx));
        check("rsp_data", rsp_data, m_exp);
        if (rsp_ready[m_idx]) begin
          m_busy = 0; m_ptr = (m_idx + 1) % N; m_done++;
        end
      end else begin
        check("rsp_valid_idle", rsp_valid, 0);
      end
      if (win >= 0) begin
        m_busy = 1; m_idx = win; m_acc = cyc;
        m_op = req_op[2*win +: 2]; m_a = req_a[32*win +: 32]; m_b = req_b[32*win +: 32];
        m_exp = fpu_eval(m_op, m_a, m_b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [1:0] op, logic [31:0] a, logic [31:0] b);
    req_op[2*i +: 2]  = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i]      = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle(string name);
    bit got = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    check(name, got, 1);
    tick();
  endtask

  task automatic run_single(int v, int idx, logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] exp);
    bit got = 0;
    set_req(idx, op, a, b);
    rsp_ready = '1;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ready[idx]) got = 1;
    end
    check($sformatf("vec%0d_accept", v), got, 1);
    tick();
    req_valid[idx] = 1'b0;
    got = 0;
    for (int t = 0; t < 30 && !got; t++) begin
      @(negedge clk);
      if (rsp_valid[idx]) begin
        got = 1;
        check($sformatf("vec%0d_rsp_data", v), rsp_data, exp);
      end
    end
    check($sformatf("vec%0d_rsp_seen", v), got, 1);
    tick();
  endtask

  typedef struct {
    int          idx;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int grants[$];
    int exp_g[5];
    bit got;
    logic [N-1:0] acc;

    vecs[0] = '{0, 2'd1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    vecs[1] = '{1, 2'd3, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000};
    vecs[2] = '{2, 2'd2, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000};
    vecs[3] = '{3, 2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h7FC0_0000};
    vecs[4] = '{0, 2'd2, 32'h40A0_0000, 32'h4040_0000, 32'h4000_0000};
    vecs[5] = '{2, 2'd3, 32'hC000_0000, 32'h4080_0000, 32'hC100_0000};
    exp_g = '{0, 1, 2, 3, 0};

    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    req_op = '0; req_a = '0; req_b = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_fpu_cs", fpu_cs, 0);
    check("rst_fpu_addr", fpu_addr, 0);
    check("rst_fpu_wdata", fpu_wdata, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_ops_done", ops_done, 0);
    reset = 1'b0;
    tick();

    // Directed single-request vectors (ADD, MUL, SUB, op 0, more)
    for (int v = 0; v < 6; v++) begin
      run_single(v, vecs[v].idx, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].exp);
      if (v == 0) check("ops_done_after_first", ops_done, 1);
    end

    // All requesters valid continuously: rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++)
      set_req(i, (i == 3) ? 2'd0 : 2'(i + 1), int_to_f32(i + 2), int_to_f32(3 * i + 1));
    rsp_ready = '1;
    for (int t = 0; t < 100 && grants.size() < 5; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) grants.push_back(i);
    end
    tick();
    req_valid = '0;
    check("rr_grant_count", grants.size(), 5);
    for (int g = 0; g < 5 && g < grants.size(); g++)
      check($sformatf("rr_grant%0d", g), grants[g], exp_g[g]);
    wait_idle("rr_idle");

    // Back-pressure on requester 1 while others wait
    for (int i = 0; i < N; i++) set_req(i, 2'((i + 1 > 3) ? 1 : i + 1), int_to_f32(10 + i), int_to_f32(i + 1));
    rsp_ready = 4'b1101;
    got = 0;
    for (int t = 0; t < 30 && !got; t++) begin
      @(negedge clk);
      if (rsp_valid[1]) got = 1;
    end
    check("bp_rsp_seen", got, 1);
    for (int j = 0; j < 10; j++) begin
      check("bp_rsp_valid", rsp_valid, 4'b0010);
      check("bp_rsp_data", rsp_data, int_to_f32(9));
      check("bp_fpu_cs", fpu_cs, 0);
      check("bp_req_ready", req_ready, 0);
      @(negedge clk);
    end
    tick();
    rsp_ready = '1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (|req_ready) break;
    end
    check("bp_next_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    wait_idle("bp_idle");

    // Reset during WR_B aborts the transaction and clears the pointer
    set_req(3, 2'd1, 32'h3F80_0000, 32'h4000_0000);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (fpu_cs && fpu_addr == 13'h000) got = 1;
    end
    check("rst_mid_wr_a_seen", got, 1);
    tick();
    reset = 1'b1;
    req_valid = '0;
    tick();
    check("rst_mid_busy", busy, 0);
    check("rst_mid_fpu_cs", fpu_cs, 0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 2'd3, int_to_f32(3 + i), int_to_f32(4));
    @(negedge clk);
    check("rst_mid_ptr0_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    got = 0;
    for (int t = 0; t < 30 && !got; t++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin
        got = 1;
        check("rst_mid_fresh_data", rsp_data, int_to_f32(12));
      end
    end
    check("rst_mid_fresh_seen", got, 1);
    tick();

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
      for (int i = 0; i < N; i++) begin
        if (acc[i] || (!req_valid[i] && $urandom_range(0, 3) == 0)) begin
          req_op[2*i +: 2]  = 2'($urandom_range(0, 3));
          req_a[32*i +: 32] = int_to_f32(int'($urandom_range(0, 2000)) - 1000);
          req_b[32*i +: 32] = int_to_f32(int'($urandom_range(0, 2000)) - 1000);
          req_valid[i]      = ($urandom_range(0, 3) != 0);
        end else if (req_valid[i] && $urandom_range(0, 49) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    rsp_ready = '1;
    wait_idle("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
